// File: rtl/sd_spi_master.sv
// sd_spi_master: SPI mode-0 master. Each accepted start sends one N-bit frame, MSB first.
// SCLK is derived from clk, and each SCLK half-period lasts CLKDIV clk cycles.
// Ports:
//   clk      system clock; all state changes on its rising edge
//   reset    asynchronous, active-high reset
//   start    transfer request; sampled only while idle
//   tx_data  frame to send; captured when start is accepted
//   cs_keep  captured with start; 1 keeps cs_n low after this frame
//   miso     serial data from the card
//   sclk     SPI clock; low when idle
//   mosi     serial data to the card; high when idle
//   cs_n     card select, active low
//   rx_data  last received frame; valid from done until the next done
//   busy     high while a transfer is in progress
//   done     one-cycle pulse when a frame completes
module sd_spi_master #(
  parameter int unsigned N      = 8,
  parameter int unsigned CLKDIV = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [N-1:0] tx_data,
  input  logic         cs_keep,
  input  logic         miso,
  output logic         sclk,
  output logic         mosi,
  output logic         cs_n,
  output logic [N-1:0] rx_data,
  output logic         busy,
  output logic         done
);

  localparam int unsigned CW = $clog2(CLKDIV + 1);
  localparam int unsigned BW = $clog2(N);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_HIGH,
    S_LOW,
    S_FINISH
  } state_t;

  state_t         state;
  logic [CW-1:0]  div_cnt;
  logic [BW-1:0]  bit_cnt;
  logic [N-1:0]   tx_sr;
  logic [N-1:0]   rx_sr;
  logic           keep_l;
  logic           div_last;

  // Flags the final clk cycle of the current SCLK half-period.
  assign div_last = (div_cnt == CW'(CLKDIV - 1));

  // Frame sequencer. The shift register holds the bits that have not been sent yet,
  // with the next bit in the MSB position. Because the register refills with ones,
  // mosi returns high by itself after the last bit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= S_IDLE;
      sclk    <= 1'b0;
      mosi    <= 1'b1;
      cs_n    <= 1'b1;
      busy    <= 1'b0;
      done    <= 1'b0;
      rx_data <= '0;
      tx_sr   <= '1;
      rx_sr   <= '0;
      div_cnt <= '0;
      bit_cnt <= '0;
      keep_l  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            // Bit N-1 goes out on mosi now; the rest waits in the register.
            tx_sr   <= {tx_data[N-2:0], 1'b1};
            mosi    <= tx_data[N-1];
            keep_l  <= cs_keep;
            cs_n    <= 1'b0;
            busy    <= 1'b1;
            div_cnt <= '0;
            bit_cnt <= '0;
            state   <= S_SETUP;
          end
        end
        S_SETUP: begin
          if (div_last) begin
            div_cnt <= '0;
            sclk    <= 1'b1;
            state   <= S_HIGH;
          end else begin
            div_cnt <= div_cnt + CW'(1);
          end
        end
        S_HIGH: begin
          if (div_last) begin
            // Capture miso at the end of the high phase, just before the falling edge.
            rx_sr   <= {rx_sr[N-2:0], miso};
            div_cnt <= '0;
            sclk    <= 1'b0;
            state   <= S_LOW;
          end else begin
            div_cnt <= div_cnt + CW'(1);
          end
        end
        S_LOW: begin
          if (div_last) begin
            div_cnt <= '0;
            mosi    <= tx_sr[N-1];
            tx_sr   <= {tx_sr[N-2:0], 1'b1};
            if (bit_cnt == BW'(N - 1)) begin
              done    <= 1'b1;
              busy    <= 1'b0;
              rx_data <= rx_sr;
              cs_n    <= ~keep_l;
              state   <= S_FINISH;
            end else begin
              bit_cnt <= bit_cnt + BW'(1);
              sclk    <= 1'b1;
              state   <= S_HIGH;
            end
          end else begin
            div_cnt <= div_cnt + CW'(1);
          end
        end
        S_FINISH: begin
          // A start arriving during this cycle is dropped, not queued.
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sd_spi_master.sv
// tb_sd_spi_master: randomized, self-checking bench for sd_spi_master.
// A timeline model predicts every output on every cycle. It counts the cycle index t
// from the accepted start and derives the SPI phase from t.
module tb_sd_spi_master;

  localparam int N  = 8;
  localparam int CD = 2;
  localparam int T  = CD * (2 * N + 1);

  logic clk = 1'b0;
  logic reset = 1'b0;

  logic         start = 1'b0, cs_keep = 1'b0, miso = 1'b1;
  logic [N-1:0] tx_data = '0;
  logic         sclk, mosi, cs_n, busy, done;
  logic [N-1:0] rx_data;

  logic         start1 = 1'b0, keep1 = 1'b0, miso1 = 1'b0;
  logic [N-1:0] tx1 = '0;
  logic         sclk1, mosi1, cs_n1, busy1, done1;
  logic [N-1:0] rx1;

  sd_spi_master #(.N(N), .CLKDIV(CD)) dut (
    .clk(clk), .reset(reset), .start(start), .tx_data(tx_data), .cs_keep(cs_keep),
    .miso(miso), .sclk(sclk), .mosi(mosi), .cs_n(cs_n), .rx_data(rx_data),
    .busy(busy), .done(done)
  );

  sd_spi_master #(.N(N), .CLKDIV(1)) dut1 (
    .clk(clk), .reset(reset), .start(start1), .tx_data(tx1), .cs_keep(keep1),
    .miso(miso1), .sclk(sclk1), .mosi(mosi1), .cs_n(cs_n1), .rx_data(rx1),
    .busy(busy1), .done(done1)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit           m_active = 1'b0;
  int           m_t = 0;
  logic [N-1:0] m_tx = '0, m_pat = '0, m_rx = '0, pat_next = '0;
  bit           m_keep = 1'b0;
  bit           m_cs = 1'b1;
  logic         e_sclk = 1'b0, e_mosi = 1'b1, e_cs = 1'b1, e_busy = 1'b0, e_done = 1'b0;
  int           p, bi, mi;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_active = 1'b0;
      m_t = 0;
      m_cs = 1'b1;
      m_rx = '0;
    end else if (!m_active) begin
      if (start) begin
        m_active = 1'b1;
        m_t = 1;
        m_tx = tx_data;
        m_keep = cs_keep;
        m_pat = pat_next;
      end
    end else begin
      m_t++;
      if (m_t == T + 1) begin
        m_rx = m_pat;
        m_cs = !m_keep;
      end
      if (m_t > T + 1) m_active = 1'b0;
    end
    e_cs = m_cs; e_sclk = 1'b0; e_mosi = 1'b1; e_busy = 1'b0; e_done = 1'b0;
    if (m_active && m_t <= T) begin
      p = (m_t - 1) / CD;          // phase 0 = setup, odd = high, even>0 = low
      bi = (p == 0) ? 0 : (p - 1) / 2;
      e_busy = 1'b1;
      e_cs = 1'b0;
      e_sclk = (p % 2) == 1;
      e_mosi = m_tx[N-1-bi];
      mi = p / 2;                  // card shifts its next bit after each falling edge
      if (mi > N - 1) mi = N - 1;
      miso <= m_pat[N-1-mi];
    end else begin
      if (m_active) e_done = 1'b1;
      miso <= 1'($urandom);
    end
  end

  // ---------------- per-cycle compare ----------------
  logic prev_sclk = 1'b0, prev_mosi = 1'b1, prev_done = 1'b0;
  int   rises = 0, dones = 0, cs_hi = 0;
  logic rise_q[$];

  always @(posedge clk) begin
    #3;
    chk("sclk", sclk, e_sclk);
    chk("mosi", mosi, e_mosi);
    chk("cs_n", cs_n, e_cs);
    chk("busy", busy, e_busy);
    chk("done", done, e_done);
    chk("rx_data", rx_data, m_rx);
    chk("sclk_while_deselected", sclk & cs_n, 0);
    chk("done_one_cycle", done & prev_done, 0);
    if (prev_sclk && sclk) chk("mosi_stable_high", mosi, prev_mosi);
    if (sclk && !prev_sclk) begin
      rises++;
      rise_q.push_back(mosi);
    end
    if (done) dones++;
    if (cs_n) cs_hi++;
    prev_sclk = sclk;
    prev_mosi = mosi;
    prev_done = done;
  end

  task automatic run_frame(input logic [N-1:0] tx, input logic [N-1:0] pat,
                           input bit keep, output int cyc);
    @(negedge clk);
    start = 1'b1; tx_data = tx; cs_keep = keep; pat_next = pat;
    @(negedge clk);
    start = 1'b0; tx_data = N'($urandom); cs_keep = 1'($urandom);
    cyc = 1;
    while (done !== 1'b1 && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    if (cyc >= 200) chk("frame_timeout", 0, 1);
  endtask

  initial begin
    int cyc, d0, r0, h0, bc, hi, dbl, mlow, c;
    logic [N-1:0] v, tx, pat;
    logic ps;

    #1 reset = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("reset_sclk", sclk, 0);
    chk("reset_mosi", mosi, 1);
    chk("reset_cs_n", cs_n, 1);
    chk("reset_busy", busy, 0);
    chk("reset_rx", rx_data, 0);
    @(negedge clk) reset = 1'b0;

    // Send 0xA5 with miso returning 0x3C.
    rise_q.delete();
    run_frame(8'hA5, 8'h3C, 1'b0, cyc);
    chk("t1_done_cycle", cyc, 35);
    chk("t1_rise_count", rise_q.size(), 8);
    v = '0;
    for (int i = 0; i < rise_q.size() && i < N; i++) v = {v[N-2:0], rise_q[i]};
    chk("t1_mosi_bits", v, 8'hA5);
    chk("t1_rx", rx_data, 8'h3C);
    @(negedge clk);
    chk("t1_cs_after", cs_n, 1);

    // Hold start high, then pulse it again during busy: expect exactly one frame.
    d0 = dones; r0 = rises;
    @(negedge clk);
    start = 1'b1; tx_data = N'($urandom); cs_keep = 1'b0; pat_next = N'($urandom);
    repeat (10) @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (40) @(negedge clk);
    chk("t2_one_done", dones - d0, 1);
    chk("t2_sclk_pulses", rises - r0, 8);

    // Two frames; cs_n stays low between them.
    r0 = rises;
    run_frame(8'h40, 8'h81, 1'b1, cyc);
    chk("t3_f1_cycle", cyc, 35);
    chk("t3_cs_kept", cs_n, 0);
    h0 = cs_hi;
    run_frame(8'h95, 8'h6E, 1'b0, cyc);
    chk("t3_rx", rx_data, 8'h6E);
    chk("t3_cs_high_cycles", cs_hi - h0, 1);
    chk("t3_sclk_pulses", rises - r0, 16);
    @(negedge clk);
    chk("t3_cs_after", cs_n, 1);

    // Assert reset partway through a frame.
    d0 = dones;
    @(negedge clk);
    start = 1'b1; tx_data = N'($urandom); cs_keep = 1'b1; pat_next = N'($urandom);
    @(negedge clk);
    start = 1'b0;
    repeat (11) @(negedge clk);
    chk("t4_busy_before", busy, 1);
    #1 reset = 1'b1;
    #1;
    chk("t4_sclk", sclk, 0);
    chk("t4_mosi", mosi, 1);
    chk("t4_cs_n", cs_n, 1);
    chk("t4_busy", busy, 0);
    chk("t4_done", done, 0);
    @(negedge clk) reset = 1'b0;
    repeat (20) @(negedge clk);
    chk("t4_no_done", dones - d0, 0);
    run_frame(8'hC3, 8'h5A, 1'b0, cyc);
    chk("t4_after_cycle", cyc, 35);
    chk("t4_after_rx", rx_data, 8'h5A);

    // Randomized frames.
    for (int k = 0; k < 8; k++) begin
      tx = N'($urandom);
      pat = N'($urandom);
      run_frame(tx, pat, 1'($urandom), cyc);
      chk("rand_cycle", cyc, 35);
      chk("rand_rx", rx_data, pat);
    end

    // CLKDIV=1 instance: 0xFF out, miso tied low.
    @(negedge clk);
    start1 = 1'b1; tx1 = 8'hFF; keep1 = 1'b0;
    @(negedge clk);
    start1 = 1'b0;
    bc = 0; hi = 0; dbl = 0; mlow = 0; c = 0; ps = 1'b0;
    while (done1 !== 1'b1 && c < 100) begin
      if (busy1) bc++;
      if (sclk1) hi++;
      if (sclk1 && ps) dbl++;
      if (busy1 && !mosi1) mlow++;
      ps = sclk1;
      @(negedge clk);
      c++;
    end
    chk("t5_no_timeout", c < 100, 1);
    chk("t5_busy_cycles", bc, 17);
    chk("t5_sclk_high_cycles", hi, 8);
    chk("t5_sclk_period", dbl, 0);
    chk("t5_mosi_high", mlow, 0);
    chk("t5_rx", rx1, 8'h00);
    chk("t5_cs_n", cs_n1, 1);
    @(negedge clk);
    chk("t5_idle_mosi", mosi1, 1);

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
